// File: rtl/lane_rr_scheduler.sv
// Round-robin scheduler: NREQ 32-bit requesters share one byte lane, MSB byte first, 4 slots per word.
// Define LANE_PARITY_EN to add a registered even-parity output (parity_out) alongside data_out.
module lane_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 2
) (
  input  logic               clk_4f,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [7:0]         data_out,
  output logic               valid_out,
  output logic [1:0]         byte_idx,
  output logic [SRC_W-1:0]   src_id,
`ifdef LANE_PARITY_EN
  output logic               parity_out,
`endif
  output logic               frame_start
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_word;
  logic [SRC_W-1:0] r_last_grant, r_src;
  logic [7:0]       r_data;
  logic [1:0]       r_idx;
  logic             r_valid, r_fs;

  logic             w_load, w_any, w_xfer, w_hi_any, w_lo_any;
  logic [SRC_W-1:0] w_hi, w_lo, w_winner;
  logic [31:0]      w_win_word;
  logic [7:0]       w_data_nxt;
  logic [1:0]       w_idx_nxt;
  logic             w_valid_nxt, w_fs_nxt;

  assign w_load = (r_state == IDLE) || (r_idx == 2'd3);
  assign w_xfer = w_load && w_any && !reset;

  // Round-robin: lowest valid index above last_grant wins, else wrap to lowest valid index overall.
  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latches appear.
  always_comb begin
    w_hi_any   = 1'b0;
    w_lo_any   = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    w_win_word = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        if (j > int'(r_last_grant)) begin
          w_hi_any = 1'b1;
          w_hi     = SRC_W'(j);
        end else begin
          w_lo_any = 1'b1;
          w_lo     = SRC_W'(j);
        end
      end
    end
    w_any    = w_hi_any || w_lo_any;
    w_winner = w_hi_any ? w_hi : w_lo;
    for (int j = 0; j < NREQ; j++) begin
      if (SRC_W'(j) == w_winner) w_win_word = req_data[32*j +: 32];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk_4f) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = SEND;
      SEND:    if (r_idx == 2'd3 && !w_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = w_xfer && (SRC_W'(j) == w_winner);
    end
  end

  always_comb begin
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_fs_nxt    = r_fs;
    if (w_xfer) begin
      w_data_nxt  = w_win_word[31:24];
      w_idx_nxt   = 2'd0;
      w_valid_nxt = 1'b1;
      w_fs_nxt    = 1'b1;
    end else if (r_state == SEND && r_idx != 2'd3) begin
      w_idx_nxt = r_idx + 2'd1;
      w_fs_nxt  = 1'b0;
      case (r_idx)
        2'd0:    w_data_nxt = r_word[23:16];
        2'd1:    w_data_nxt = r_word[15:8];
        default: w_data_nxt = r_word[7:0];
      endcase
    end else if (r_state == SEND) begin
      w_data_nxt  = 8'h00;
      w_idx_nxt   = 2'd0;
      w_valid_nxt = 1'b0;
      w_fs_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_data       <= 8'h00;
      r_idx        <= 2'd0;
      r_valid      <= 1'b0;
      r_fs         <= 1'b0;
      r_src        <= '0;
      r_last_grant <= SRC_W'(NREQ - 1);
    end else begin
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_fs    <= w_fs_nxt;
      if (w_xfer) begin
        r_src        <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  // NOTE: the latched word is pure datapath and is only read after a load, so it carries no reset.
  always_ff @(posedge clk_4f) begin
    if (w_xfer) r_word <= w_win_word;
  end

`ifdef LANE_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk_4f) begin
    if (reset) r_parity <= 1'b0;
    else       r_parity <= ^w_data_nxt;
  end
  assign parity_out = r_parity;
`endif

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_idx    = r_idx;
  assign src_id      = r_src;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Self-checking bench for lane_rr_scheduler: a cycle model pushes expected bytes to a scoreboard queue.
module tb_lane_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int SRC_W = 2;

  logic               clk_4f = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [7:0]         data_out;
  logic               valid_out;
  logic [1:0]         byte_idx;
  logic [SRC_W-1:0]   src_id;
  logic               frame_start;
`ifdef LANE_PARITY_EN
  logic               parity_out;
`endif

  lane_rr_scheduler #(.NREQ(NREQ), .SRC_W(SRC_W)) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_idx    (byte_idx),
    .src_id      (src_id),
`ifdef LANE_PARITY_EN
    .parity_out  (parity_out),
`endif
    .frame_start (frame_start)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct packed {
    logic [7:0]       data;
    logic [1:0]       idx;
    logic [SRC_W-1:0] src;
    logic             fs;
  } beat_t;

  beat_t            sb_q[$];
  int               grant_log[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic             m_sending;
  logic [1:0]       m_byte;
  int               m_last;
  logic [SRC_W-1:0] m_src;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic monitor();
    beat_t e;
    check("valid_out", valid_out, m_sending);
    if (m_sending) begin
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("data_out", data_out, e.data);
        check("byte_idx", byte_idx, e.idx);
        check("src_id", src_id, e.src);
        check("frame_start", frame_start, e.fs);
`ifdef LANE_PARITY_EN
        check("parity_out", parity_out, ^e.data);
`endif
      end
    end else begin
      check("idle_data", data_out, 0);
      check("idle_idx", byte_idx, 0);
      check("idle_fs", frame_start, 0);
      check("idle_src", src_id, m_src);
`ifdef LANE_PARITY_EN
      check("idle_parity", parity_out, 0);
`endif
    end
  endtask

  // One clk_4f period: check the combinational grant, step the model, then sample outputs at the negedge.
  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    logic [31:0]     word;
    int              win;
    exp_ready = '0;
    win       = -1;
    #1;
    if (!reset && (!m_sending || m_byte == 2'd3)) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    for (int j = 0; j < NREQ; j++) if (req_ready[j]) grant_log.push_back(j);
    if (reset) begin
      sb_q.delete();
      m_sending = 1'b0;
      m_byte    = 2'd0;
      m_last    = NREQ - 1;
      m_src     = '0;
    end else if (win >= 0) begin
      word = req_data[32*win +: 32];
      for (int b = 0; b < 4; b++)
        sb_q.push_back('{data: word[31-8*b -: 8], idx: 2'(b), src: SRC_W'(win), fs: (b == 0)});
      m_sending = 1'b1;
      m_byte    = 2'd0;
      m_last    = win;
      m_src     = SRC_W'(win);
    end else if (m_sending && m_byte != 2'd3) begin
      m_byte = m_byte + 2'd1;
    end else begin
      m_sending = 1'b0;
    end
    @(posedge clk_4f);
    @(negedge clk_4f);
    if (win >= 0) req_valid[win] = 1'b0;
    monitor();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_sending || req_valid != '0) && n < 40) begin
      cycle();
      n++;
    end
    check("drain_bound", (m_sending || req_valid != '0), 0);
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    m_sending = 1'b0;
    m_byte    = 2'd0;
    m_last    = NREQ - 1;
    m_src     = '0;
    @(negedge clk_4f);
    cycle();
    do_reset();
    cycle();

    // Single word from requester 0, valid for one cycle only.
    base = grant_log.size();
    req_data[31:0] = 32'h2E9F1305;
    req_valid      = 4'b0001;
    drain();
    check("t1_ngrant", grant_log.size() - base, 1);
    check("t1_grant", grant_log[base], 0);

    // All four valid from a fresh reset: strict 0,1,2,3 order, 16 contiguous bytes.
    do_reset();
    base      = grant_log.size();
    req_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_valid = 4'b1111;
    drain();
    check("t2_ngrant", grant_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_grant%0d", i), grant_log[base+i], i);

    // Serve req1, then req1 and req3 together: req3 goes first.
    base           = grant_log.size();
    req_data[63:32] = 32'hA1A2A3A4;
    req_valid      = 4'b0010;
    drain();
    req_data[63:32]  = 32'hB1B2B3B4;
    req_data[127:96] = 32'hD1D2D3D4;
    req_valid        = 4'b1010;
    drain();
    check("t3_ngrant", grant_log.size() - base, 3);
    check("t3_first", grant_log[base+1], 3);
    check("t3_second", grant_log[base+2], 1);

    // Reset while byte_idx==2 aborts the frame; req0 then wins over req2.
    req_data[31:0] = 32'h55667788;
    req_valid      = 4'b0001;
    cycle();
    cycle();
    cycle();
    check("t4_pre_idx", byte_idx, 2);
    req_data[95:64] = 32'h99AABBCC;
    req_valid       = 4'b0101;
    base            = grant_log.size();
    do_reset();
    drain();
    check("t4_ngrant", grant_log.size() - base, 2);
    check("t4_first", grant_log[base], 0);
    check("t4_second", grant_log[base+1], 2);

    // req2 drops valid and scrambles its word after the grant; latched bytes go out unchanged.
    base            = grant_log.size();
    req_data[95:64] = 32'hC0FFEE42;
    req_valid       = 4'b0100;
    cycle();
    req_data[95:64] = 32'hDEADBEEF;
    drain();
    check("t5_grant", grant_log[base], 2);

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
